udivider_pipe_param: RTL and testbench

- Parametrised successor to the fixed 8/4 unsigned divider.
- Iterative restoring divider: one quotient bit per cycle, configurable operand widths, per-operation signed/unsigned mode.
- Uses a valid/ready accept handshake instead of edge detection, and reports divide-by-zero and signed-overflow flags.
- Sits behind arithmetic issue logic as a multi-cycle, non-pipelined functional unit.

---
 rtl/udivider_pipe_param_if.sv | 31 +++
 rtl/udivider_pipe_param.sv | 86 ++++++++
 tb/tb_udivider_pipe_param.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udivider_pipe_param_if.sv
// udivider_pipe_param_if: request/result bundle for the iterative divider.
// Signals:
//   iDIVVLD    request valid (level)          oREADY     unit idle / can accept
//   iSIGNED    two's-complement mode          iDIVIDEND  dividend, DW bits
//   iDIVISOR   divisor, VW bits               oQUOTIENT  quotient, DW bits
//   oREMAINDER remainder, VW bits             oDIVZERO   divisor was zero
//   oOVF       signed overflow                oDONE      one-cycle result pulse
// master drives requests, slave is the divider.
interface udivider_pipe_param_if #(
    parameter int DW = 16,
    parameter int VW = 8
);
    logic          iDIVVLD;
    logic          oREADY;
    logic          iSIGNED;
    logic [DW-1:0] iDIVIDEND;
    logic [VW-1:0] iDIVISOR;
    logic [DW-1:0] oQUOTIENT;
    logic [VW-1:0] oREMAINDER;
    logic          oDIVZERO;
    logic          oOVF;
    logic          oDONE;
    modport master (
        output iDIVVLD, iSIGNED, iDIVIDEND, iDIVISOR,
        input  oREADY, oQUOTIENT, oREMAINDER, oDIVZERO, oOVF, oDONE
    );
    modport slave (
        input  iDIVVLD, iSIGNED, iDIVIDEND, iDIVISOR,
        output oREADY, oQUOTIENT, oREMAINDER, oDIVZERO, oOVF, oDONE
    );
endinterface

// File: rtl/udivider_pipe_param.sv
// udivider_pipe_param: iterative restoring divider, one quotient bit per cycle.
// Ports:
//   CLK       clock, all state on posedge
//   iRESET_N  asynchronous active-low reset
//   bus       udivider_pipe_param_if.slave (request handshake, operands, results, flags)
// Latency is DW+2 cycles from accept to oDONE in every case; results and flags
// hold until the next oDONE.
module udivider_pipe_param #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input logic                  CLK,
    input logic                  iRESET_N,
    udivider_pipe_param_if.slave bus
);
    localparam int CW = $clog2(DW + 1);
    typedef enum logic [1:0] {IDLE, ITER, FIX} stateT;
    stateT         state, nextState;
    logic [CW-1:0] count;
    logic [DW-1:0] quoReg;
    logic [VW-1:0] remReg, divReg, diff;
    logic [VW:0]   shifted;
    logic          negQuo, negRem, zeroDiv, ovfDiv;
    logic          accept, borrow, dividendNeg, divisorNeg;
    assign accept      = bus.iDIVVLD && bus.oREADY;
    assign bus.oREADY  = state == IDLE;
    assign dividendNeg = bus.iSIGNED && bus.iDIVIDEND[DW-1];
    assign divisorNeg  = bus.iSIGNED && bus.iDIVISOR[VW-1];
    // quoReg holds the not-yet-consumed dividend bits in its top and the
    // quotient bits shifted in at its bottom
    assign shifted = {remReg, quoReg[DW-1]};
    assign borrow  = shifted < {1'b0, divReg};
    // the kept difference is always below the divisor, so VW bits suffice
    assign diff    = shifted[VW-1:0] - divReg;
    always_ff @(posedge CLK or negedge iRESET_N) begin
        if (!iRESET_N)
            state <= IDLE;
        else
            state <= nextState;
    end
    always_comb begin
        nextState = state == IDLE ? (accept ? ITER : IDLE)
                  : state == ITER ? (count == CW'(1) ? FIX : ITER)
                  : IDLE;
    end
    always_ff @(posedge CLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            count          <= '0;
            quoReg         <= '0;
            remReg         <= '0;
            divReg         <= '0;
            negQuo         <= 1'b0;
            negRem         <= 1'b0;
            zeroDiv        <= 1'b0;
            ovfDiv         <= 1'b0;
            bus.oQUOTIENT  <= '0;
            bus.oREMAINDER <= '0;
            bus.oDIVZERO   <= 1'b0;
            bus.oOVF       <= 1'b0;
            bus.oDONE      <= 1'b0;
        end else begin
            bus.oDONE <= 1'b0;
            if (accept) begin
                count   <= CW'(DW);
                quoReg  <= dividendNeg ? -bus.iDIVIDEND : bus.iDIVIDEND;
                remReg  <= '0;
                divReg  <= divisorNeg ? -bus.iDIVISOR : bus.iDIVISOR;
                negQuo  <= dividendNeg ^ divisorNeg;
                negRem  <= dividendNeg;
                zeroDiv <= bus.iDIVISOR == '0;
                ovfDiv  <= bus.iSIGNED && bus.iDIVIDEND == {1'b1, {(DW-1){1'b0}}} && &bus.iDIVISOR;
            end else if (state == ITER) begin
                count  <= count - 1'b1;
                remReg <= borrow ? shifted[VW-1:0] : diff;
                quoReg <= {quoReg[DW-2:0], ~borrow};
            end else if (state == FIX) begin
                // overflow needs no override: |min| / 1 already yields the min bit pattern
                bus.oQUOTIENT  <= zeroDiv ? '1 : negQuo ? -quoReg : quoReg;
                bus.oREMAINDER <= zeroDiv ? '0 : negRem ? -remReg : remReg;
                bus.oDIVZERO   <= zeroDiv;
                bus.oOVF       <= ovfDiv;
                bus.oDONE      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_udivider_pipe_param.sv
// tb_udivider_pipe_param: directed and randomized checks of udivider_pipe_param
// against an arithmetic reference model (DW=16, VW=8).
module tb_udivider_pipe_param;
    localparam int DW = 16;
    localparam int VW = 8;
    localparam int LAT = DW + 2;
    logic CLK = 1'b0;
    logic iRESET_N = 1'b1;
    int   errors = 0;
    int   checks = 0;
    always #5 CLK = ~CLK;
    udivider_pipe_param_if #(.DW(DW), .VW(VW)) bus ();
    udivider_pipe_param #(.DW(DW), .VW(VW)) dut (.CLK(CLK), .iRESET_N(iRESET_N), .bus(bus));

    function automatic void refDiv(input logic s, input logic [DW-1:0] a, input logic [VW-1:0] b,
                                   output logic [DW-1:0] q, output logic [VW-1:0] r,
                                   output logic dz, output logic ov);
        int sa, sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q  = '1;
            r  = '0;
            dz = 1'b1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            if (sa == -(1 << (DW - 1)) && sb == -1) begin
                q  = DW'(1 << (DW - 1));
                r  = '0;
                ov = 1'b1;
            end else begin
                q = DW'(sa / sb);
                r = VW'(sa % sb);
            end
        end else begin
            q = a / DW'(b);
            r = VW'(a % DW'(b));
        end
    endfunction

    task automatic doOp(input logic s, input logic [DW-1:0] a, input logic [VW-1:0] b,
                        output logic [DW-1:0] q, output logic [VW-1:0] r,
                        output logic dz, output logic ov, output int lat, output int busyReady);
        int w;
        w = 0;
        @(negedge CLK);
        while (!bus.oREADY && w < 50) begin
            @(negedge CLK);
            w++;
        end
        bus.iSIGNED   = s;
        bus.iDIVIDEND = a;
        bus.iDIVISOR  = b;
        bus.iDIVVLD   = 1'b1;
        lat = 0;
        busyReady = 0;
        q = 'x;
        r = 'x;
        dz = 1'bx;
        ov = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                bus.iDIVVLD   = 1'b0;
                bus.iSIGNED   = 1'($urandom_range(0, 1));
                bus.iDIVIDEND = DW'($urandom);
                bus.iDIVISOR  = VW'($urandom);
            end
            if (bus.oDONE) begin
                lat = k;
                q = bus.oQUOTIENT;
                r = bus.oREMAINDER;
                dz = bus.oDIVZERO;
                ov = bus.oOVF;
                if (!bus.oREADY) busyReady++;
                break;
            end
            if (bus.oREADY) busyReady++;
        end
    endtask

    task automatic test_power_on();
        #2 iRESET_N = 1'b0;
        #1;
        checks++;
        if (bus.oREADY !== 1'b1 || bus.oDONE !== 1'b0 || bus.oQUOTIENT !== '0 ||
            bus.oREMAINDER !== '0 || bus.oDIVZERO !== 1'b0 || bus.oOVF !== 1'b0) begin
            errors++;
            $display("FAIL power_on rdy=%b done=%b q=%h r=%h dz=%b ov=%b want rdy=1 rest 0",
                     bus.oREADY, bus.oDONE, bus.oQUOTIENT, bus.oREMAINDER, bus.oDIVZERO, bus.oOVF);
        end
        repeat (2) @(negedge CLK);
        iRESET_N = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [DW-1:0] a [2] = '{16'd1000, 16'hFC18};
        logic [DW-1:0] eq [2] = '{16'h008E, 16'd9219};
        logic [VW-1:0] er [2] = '{8'h06, 8'h03};
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dz, ov;
        int lat, br;
        for (int i = 0; i < 2; i++) begin
            doOp(1'b0, a[i], 8'd7, q, r, dz, ov, lat, br);
            checks++;
            if (lat !== LAT) begin errors++; $display("FAIL unsigned[%0d] latency got %0d want %0d", i, lat, LAT); end
            checks++;
            if (br !== 0) begin errors++; $display("FAIL unsigned[%0d] ready while busy count got %0d want 0", i, br); end
            checks++;
            if (q !== eq[i] || r !== er[i]) begin
                errors++;
                $display("FAIL unsigned[%0d] q/r got %h/%h want %h/%h", i, q, r, eq[i], er[i]);
            end
            checks++;
            if (dz !== 1'b0 || ov !== 1'b0) begin errors++; $display("FAIL unsigned[%0d] flags got %b%b want 00", i, dz, ov); end
        end
    endtask

    task automatic test_signed();
        logic [DW-1:0] a [3] = '{16'hFC18, 16'd1000, 16'hFC18};
        logic [VW-1:0] b [3] = '{8'hF9, 8'hF9, 8'h07};
        logic [DW-1:0] eq [3] = '{16'h008E, 16'hFF72, 16'hFF72};
        logic [VW-1:0] er [3] = '{8'hFA, 8'h06, 8'hFA};
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dz, ov;
        int lat, br;
        for (int i = 0; i < 3; i++) begin
            doOp(1'b1, a[i], b[i], q, r, dz, ov, lat, br);
            checks++;
            if (q !== eq[i] || r !== er[i] || lat !== LAT || dz !== 1'b0 || ov !== 1'b0) begin
                errors++;
                $display("FAIL signed[%0d] q/r/lat/dz/ov got %h/%h/%0d/%b/%b want %h/%h/%0d/0/0",
                         i, q, r, lat, dz, ov, eq[i], er[i], LAT);
            end
        end
    endtask

    task automatic test_divzero();
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dz, ov;
        int lat, br;
        for (int m = 0; m < 2; m++) begin
            doOp(1'(m), 16'd1234, 8'd0, q, r, dz, ov, lat, br);
            checks++;
            if (q !== 16'hFFFF || r !== 8'h00 || dz !== 1'b1 || ov !== 1'b0 || lat !== LAT) begin
                errors++;
                $display("FAIL divzero[mode %0d] q/r/dz/ov/lat got %h/%h/%b/%b/%0d want ffff/00/1/0/%0d",
                         m, q, r, dz, ov, lat, LAT);
            end
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dz, ov;
        int lat, br;
        doOp(1'b1, 16'h8000, 8'hFF, q, r, dz, ov, lat, br);
        checks++;
        if (q !== 16'h8000 || r !== 8'h00 || ov !== 1'b1 || dz !== 1'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL overflow_signed q/r/ov/dz/lat got %h/%h/%b/%b/%0d want 8000/00/1/0/%0d", q, r, ov, dz, lat, LAT);
        end
        doOp(1'b0, 16'h8000, 8'hFF, q, r, dz, ov, lat, br);
        checks++;
        if (q !== 16'h0080 || r !== 8'h80 || ov !== 1'b0 || dz !== 1'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL overflow_unsigned q/r/ov/dz/lat got %h/%h/%b/%b/%0d want 0080/80/0/0/%0d", q, r, ov, dz, lat, LAT);
        end
    endtask

    task automatic test_reset();
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic dz, ov;
        int lat, br, dones;
        doOp(1'b1, 16'd1000, 8'hF9, q, r, dz, ov, lat, br);
        @(negedge CLK);
        bus.iSIGNED   = 1'b0;
        bus.iDIVIDEND = 16'd1000;
        bus.iDIVISOR  = 8'd7;
        bus.iDIVVLD   = 1'b1;
        @(negedge CLK);
        bus.iDIVVLD = 1'b0;
        repeat (4) @(negedge CLK);
        #2 iRESET_N = 1'b0;
        #1;
        checks++;
        if (bus.oREADY !== 1'b1 || bus.oDONE !== 1'b0 || bus.oQUOTIENT !== '0 ||
            bus.oREMAINDER !== '0 || bus.oDIVZERO !== 1'b0 || bus.oOVF !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop rdy=%b done=%b q=%h r=%h dz=%b ov=%b want rdy=1 rest 0",
                     bus.oREADY, bus.oDONE, bus.oQUOTIENT, bus.oREMAINDER, bus.oDIVZERO, bus.oOVF);
        end
        @(negedge CLK);
        iRESET_N = 1'b1;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (bus.oDONE) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL reset_no_done pulses got %0d want 0", dones); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, br, holdBad;
        logic [DW-1:0] q1, q2;
        logic [VW-1:0] r1, r2;
        d1 = 0;
        d2 = 0;
        br = 0;
        holdBad = 0;
        q1 = 'x;
        q2 = 'x;
        r1 = 'x;
        r2 = 'x;
        @(negedge CLK);
        bus.iSIGNED   = 1'b0;
        bus.iDIVIDEND = 16'd255;
        bus.iDIVISOR  = 8'd15;
        bus.iDIVVLD   = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge CLK);
            if (k == 3) bus.iDIVIDEND = 16'd254;
            if (bus.oDONE) begin
                if (d1 == 0) begin
                    d1 = k;
                    q1 = bus.oQUOTIENT;
                    r1 = bus.oREMAINDER;
                end else begin
                    d2 = k;
                    q2 = bus.oQUOTIENT;
                    r2 = bus.oREMAINDER;
                    bus.iDIVVLD = 1'b0;
                    break;
                end
            end else begin
                if (bus.oREADY) br++;
                if (d1 != 0 && (bus.oQUOTIENT !== 16'd17 || bus.oREMAINDER !== 8'd0)) holdBad++;
            end
        end
        bus.iDIVVLD = 1'b0;
        checks++;
        if (d1 !== LAT || q1 !== 16'd17 || r1 !== 8'd0) begin
            errors++;
            $display("FAIL b2b_first at/q/r got %0d/%0d/%0d want %0d/17/0", d1, q1, r1, LAT);
        end
        checks++;
        if (d2 !== 2 * LAT || q2 !== 16'd16 || r2 !== 8'd14) begin
            errors++;
            $display("FAIL b2b_second at/q/r got %0d/%0d/%0d want %0d/16/14", d2, q2, r2, 2 * LAT);
        end
        checks++;
        if (br !== 0) begin errors++; $display("FAIL b2b_busy_ready count got %0d want 0", br); end
        checks++;
        if (holdBad !== 0) begin errors++; $display("FAIL b2b_hold changes got %0d want 0", holdBad); end
    endtask

    task automatic test_random();
        logic s;
        logic [DW-1:0] a, q, eq;
        logic [VW-1:0] b, r, er;
        logic dz, ov, edz, eov;
        int lat, br, pick;
        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom_range(0, 1));
            a = DW'($urandom);
            b = VW'($urandom);
            pick = $urandom_range(0, 7);
            if (pick == 0) b = '0;
            if (pick == 1) begin a = 16'h8000; b = 8'hFF; end
            if (pick == 2) b = 8'd1;
            if (pick == 3) b = 8'h80;
            refDiv(s, a, b, eq, er, edz, eov);
            doOp(s, a, b, q, r, dz, ov, lat, br);
            checks++;
            if (q !== eq || r !== er) begin
                errors++;
                $display("FAIL random[%0d] s=%b %h/%h q/r got %h/%h want %h/%h", i, s, a, b, q, r, eq, er);
            end
            checks++;
            if (dz !== edz || ov !== eov) begin
                errors++;
                $display("FAIL random[%0d] s=%b %h/%h dz/ov got %b/%b want %b/%b", i, s, a, b, dz, ov, edz, eov);
            end
            checks++;
            if (lat !== LAT || br !== 0) begin
                errors++;
                $display("FAIL random[%0d] latency/ready_busy got %0d/%0d want %0d/0", i, lat, br, LAT);
            end
        end
    endtask

    initial begin
        bus.iDIVVLD   = 1'b0;
        bus.iSIGNED   = 1'b0;
        bus.iDIVIDEND = '0;
        bus.iDIVISOR  = '0;
        test_power_on();
        test_unsigned();
        test_signed();
        test_divzero();
        test_overflow();
        test_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
